regfile_scan: RTL and testbench
===============================

# regfile_scan

Hardware sequencer that sits on the initiator side of the 32x32 register file port set (`ctrl_writeEn`/`ctrl_writeReg`/`data_writeReg`, `ctrl_readRegA`/`ctrl_readRegB`/`data_readRegA`/`data_readRegB`).

- On `start`, it can optionally fill every register with a deterministic pattern.
- It then reads every register through both read ports, checks that port A matches port B, and streams `{index, data}` out over a valid/ready handshake.
- Used for bring-up, self-test and debug dump of the register file.

## Interface
Parameters:
- `NUM_REGS`, 32: number of registers scanned; indices 0..NUM_REGS-1.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: register data width.

Ports:
- `clock`, in, 1: single clock; all state changes on posedge.
- `ctrl_reset`, in, 1: reset; asynchronous, active-low (0 = reset).
- `start`, in, 1: begin a scan; sampled only in IDLE.
- `fill_en`, in, 1: sampled with `start`. 1 = FILL phase before the dump; 0 = dump only.
- `pattern_invert`, in, 1: sampled with `start`. Inverts the fill pattern.
- `ctrl_writeEn`, out, 1: register file write enable.
- `ctrl_writeReg`, out, ADDR_W: write index.
- `data_writeReg`, out, DATA_W: write data.
- `ctrl_readRegA`, out, ADDR_W: read port A index.
- `ctrl_readRegB`, out, ADDR_W: read port B index.
- `data_readRegA`, in, DATA_W: read port A data; combinational from its index.
- `data_readRegB`, in, DATA_W: read port B data; combinational from its index.
- `out_valid`, out, 1: dump beat valid.
- `out_ready`, in, 1: consumer accepts the beat.
- `out_index`, out, ADDR_W: register index of the beat.
- `out_data`, out, DATA_W: port A data of the beat.
- `out_mismatch`, out, 1: this beat had A != B.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at the end of a scan.
- `mismatch_count`, out, ADDR_W+1: number of A/B mismatches in the current or last scan.

## Operation
- States: IDLE, FILL, RD_ADDR, RD_CAP, EMIT, DONE.
- IDLE:
  - `start`=1 latches `fill_en` and `pattern_invert`, clears `idx` and `mismatch_count`.
  - Next state is FILL if `fill_en`=1, otherwise RD_ADDR.
- FILL: one register per cycle.
  - Drives `ctrl_writeEn`=1, `ctrl_writeReg`=idx, `data_writeReg`=pattern(idx).
  - pattern(idx) = the zero-extended idx byte replicated four times, e.g. idx 5 -> 0x05050505. If `pattern_invert` is set, the value is XORed with all-ones.
  - After idx = NUM_REGS-1: idx clears, next state RD_ADDR.
  - Register 0 is written like any other register; hardwiring is the register file's concern.
- RD_ADDR: registers `ctrl_readRegA` = `ctrl_readRegB` = idx. `ctrl_writeEn`=0 in every state except FILL.
- RD_CAP:
  - Captures `data_readRegA` into `out_data`; `out_mismatch` = (A != B); `out_index` = idx.
  - If mismatch, `mismatch_count` += 1. Maximum value is NUM_REGS, so the counter never wraps.
- EMIT:
  - `out_valid`=1. `out_index`, `out_data` and `out_mismatch` are held stable until `out_ready`=1.
  - On the handshake: if idx = NUM_REGS-1, go to DONE; otherwise idx += 1 and go to RD_ADDR.
- DONE: `done`=1 for one cycle, then IDLE. `mismatch_count` holds until the next `start`.
- Boundary conditions:
  - `start` outside IDLE is ignored, including in DONE.
  - `out_ready` outside EMIT is ignored.
  - Backpressure stalls only EMIT; no beat is dropped or duplicated.
- Reset (asserted asynchronously, at any time including mid-FILL):
  - State goes to IDLE; idx = 0; counter = 0.
  - All outputs go to 0 immediately, including `ctrl_writeEn`, so no partial write is issued after reset.
  - Register file contents are not restored.

## Timing
- `start` to first write: 1 cycle (FILL entered on the next posedge).
- Fill phase: exactly NUM_REGS cycles with `ctrl_writeEn` high.
- Per register dump: 3 cycles when `out_ready` is held high (RD_ADDR, RD_CAP, EMIT), plus one cycle per cycle of backpressure.
- Full scan with `out_ready`=1:
  - `fill_en`=1: 1 + 32 + 96 + 1 = 130 cycles from `start` to the `done` pulse.
  - `fill_en`=0: 98 cycles.
- All outputs are registered; there is no combinational path from `out_ready` to any output.

## Structure
- Package `regfile_scan_pkg`:
  - state enum;
  - `pattern(idx, invert)` function;
  - default NUM_REGS/ADDR_W/DATA_W constants shared with the register file.
- Single module; no sub-module. The FSM, index counter and output register are small enough to keep inline.

## Test plan
- Fill and dump, `out_ready`=1, `pattern_invert`=0, real register file attached:
  - beats idx 0..31 with data 0x1F1F1F1F at idx 31;
  - `mismatch_count`=0;
  - `done` exactly 130 cycles after `start`.
- `pattern_invert`=1: idx 3 reads 0xFCFCFCFC; idx 0 matches the register file's r0 behaviour on both ports.
- Dump only, with random `out_ready` backpressure (~50%):
  - 32 beats, in order, none duplicated;
  - outputs stable while `out_valid`=1 and `out_ready`=0.
- Fault model forcing port B = A ^ 1 for idx 7 and 20: `out_mismatch` set on exactly those two beats; final `mismatch_count`=2.
- Reset asserted at fill cycle 10:
  - `ctrl_writeEn` drops without waiting for a clock edge;
  - `busy`=0;
  - a new scan after deassert completes normally.
- `start` pulsed during EMIT and during DONE: ignored; a single `done` pulse; no second scan begins.

Source files
------------

// File: rtl/regfile_scan_pkg.sv
// rtl/regfile_scan_pkg.sv - shared types, constants and fill pattern for the register file scanner
package regfile_scan_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD_ADDR,
    S_RD_CAP,
    S_EMIT,
    S_DONE
  } state_e;

  // Index byte replicated across the word so a stuck or swapped byte lane is visible.
  function automatic logic [31:0] pattern(input logic [7:0] idx, input logic invert);
    logic [31:0] p;
    p = {4{idx}};
    return invert ? ~p : p;
  endfunction

endpackage

// File: rtl/regfile_scan.sv
// rtl/regfile_scan.sv - register file fill / dual-port read-back / dump sequencer
module regfile_scan
  import regfile_scan_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  input  logic              fill_en,
  input  logic              pattern_invert,
  output logic              ctrl_writeEn,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [ADDR_W-1:0] ctrl_readRegA,
  output logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mismatch,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   mismatch_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                inv_q, inv_d;
  logic                write_en_q, write_en_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [ADDR_W-1:0]   read_reg_q, read_reg_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_mismatch_q, out_mismatch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     mis_cnt_q, mis_cnt_d;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    inv_d          = inv_q;
    out_index_d    = out_index_q;
    out_data_d     = out_data_q;
    out_mismatch_d = out_mismatch_q;
    mis_cnt_d      = mis_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          inv_d     = pattern_invert;
          idx_d     = '0;
          mis_cnt_d = '0;
          state_d   = fill_en ? S_FILL : S_RD_ADDR;
        end
      end
      S_FILL: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_RD_ADDR;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        out_index_d    = idx_q;
        out_data_d     = data_readRegA;
        out_mismatch_d = (data_readRegA != data_readRegB);
        if (data_readRegA != data_readRegB) begin
          mis_cnt_d = mis_cnt_q + (ADDR_W + 1)'(1);
        end
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state they belong to.
    write_en_d   = (state_d == S_FILL);
    write_reg_d  = (state_d == S_FILL) ? idx_d : '0;
    write_data_d = (state_d == S_FILL) ? DATA_W'(pattern(8'(idx_d), inv_d)) : '0;
    read_reg_d   = (state_d == S_RD_ADDR) ? idx_d : read_reg_q;
    out_valid_d  = (state_d == S_EMIT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      inv_q          <= 1'b0;
      write_en_q     <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      read_reg_q     <= '0;
      out_valid_q    <= 1'b0;
      out_index_q    <= '0;
      out_data_q     <= '0;
      out_mismatch_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mis_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      inv_q          <= inv_d;
      write_en_q     <= write_en_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      read_reg_q     <= read_reg_d;
      out_valid_q    <= out_valid_d;
      out_index_q    <= out_index_d;
      out_data_q     <= out_data_d;
      out_mismatch_q <= out_mismatch_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mis_cnt_q      <= mis_cnt_d;
    end
  end

  assign ctrl_writeEn   = write_en_q;
  assign ctrl_writeReg  = write_reg_q;
  assign data_writeReg  = write_data_q;
  assign ctrl_readRegA  = read_reg_q;
  assign ctrl_readRegB  = read_reg_q;
  assign out_valid      = out_valid_q;
  assign out_index      = out_index_q;
  assign out_data       = out_data_q;
  assign out_mismatch   = out_mismatch_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_count = mis_cnt_q;

endmodule

// File: tb/tb_regfile_scan.sv
// tb/tb_regfile_scan.sv - self-checking bench for regfile_scan with a behavioural 32x32 register file
module tb_regfile_scan;

  logic        clock;
  logic        ctrl_reset;
  logic        start;
  logic        fill_en;
  logic        pattern_invert;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        out_mismatch;
  logic        busy;
  logic        done;
  logic [5:0]  mismatch_count;

  regfile_scan dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start), .fill_en(fill_en),
    .pattern_invert(pattern_invert), .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data), .out_mismatch(out_mismatch),
    .busy(busy), .done(done), .mismatch_count(mismatch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: r0 reads as zero, random power-up contents, optional B-port fault on r7/r20.
  logic [31:0] rf [32];
  bit          rf_init = 1'b0;
  bit          fault_en = 1'b0;

  always @(posedge clock) begin
    if (!rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf_init = 1'b1;
    end else if (ctrl_writeEn) begin
      rf[ctrl_writeReg] = data_writeReg;
    end
  end

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = ((ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB]) ^
                         {31'd0, fault_en && (ctrl_readRegB == 5'd7 || ctrl_readRegB == 5'd20)};

  int          checks = 0;
  int          errors = 0;
  int          q_idx[$];
  logic [31:0] q_data[$];
  bit          q_mis[$];
  int          scan_cycles;
  int          stab_err;
  int          done_cnt;
  bit          timed_out;

  function automatic logic [31:0] exp_val(input int i, input bit inv);
    if (i == 0) return 32'd0;
    return (32'(i) * 32'h01010101) ^ (inv ? 32'hFFFF_FFFF : 32'd0);
  endfunction

  // Drives one scan and records accepted beats, latency to done, done pulses and hold violations.
  task automatic run_scan(input bit fill, input bit inv, input int ready_pct, input bit poke);
    bit          done_seen = 1'b0;
    bit          poked = 1'b0;
    bit          pv = 1'b0;
    bit          pr = 1'b0;
    int          pidx = 0;
    logic [31:0] pdata = 32'd0;
    bit          pmis = 1'b0;
    int          tail = 0;
    int          n = 0;
    int          cyc;
    q_idx.delete(); q_data.delete(); q_mis.delete();
    stab_err = 0; done_cnt = 0; scan_cycles = 0; timed_out = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; fill_en = fill; pattern_invert = inv;
    out_ready = ($urandom_range(99) < ready_pct);
    cyc = 1;
    while (tail < 8) begin
      @(posedge clock); #1;
      start = 1'b0;
      out_ready = ($urandom_range(99) < ready_pct);
      cyc++;
      @(negedge clock);
      if (pv && !pr) begin
        if (out_valid !== 1'b1 || out_index !== 5'(pidx) || out_data !== pdata || out_mismatch !== pmis)
          stab_err++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        q_idx.push_back(int'(out_index)); q_data.push_back(out_data); q_mis.push_back(out_mismatch);
      end
      if (poke && out_valid === 1'b1 && !poked) begin
        start = 1'b1; poked = 1'b1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (!done_seen) begin
          scan_cycles = cyc; done_seen = 1'b1;
          if (poke) start = 1'b1;
        end
      end
      pv = (out_valid === 1'b1); pr = out_ready;
      pidx = int'(out_index); pdata = out_data; pmis = out_mismatch;
      if (done_seen) tail++;
      n++;
      if (n > 3000) begin
        timed_out = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    ctrl_reset = 1'b0; start = 1'b0; fill_en = 1'b0; pattern_invert = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({ctrl_writeEn, out_valid, busy, done, out_mismatch} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {ctrl_writeEn, out_valid, busy, done, out_mismatch});
    end
    checks++;
    if (mismatch_count !== 6'd0 || out_data !== 32'd0 || ctrl_readRegA !== 5'd0) begin
      errors++; $display("FAIL reset_values got cnt=%0d data=%h ra=%0d exp 0", mismatch_count, out_data, ctrl_readRegA);
    end
    @(posedge clock); #1 ctrl_reset = 1'b1;
  endtask

  task automatic test_fill_dump;
    run_scan(1'b1, 1'b0, 100, 1'b0);
    checks++;
    if (timed_out || q_idx.size() != 32) begin
      errors++; $display("FAIL fill_beats got %0d (timeout %0d) exp 32", q_idx.size(), timed_out);
    end
    for (int i = 0; i < q_idx.size() && i < 32; i++) begin
      checks++;
      if (q_idx[i] != i || q_data[i] !== exp_val(i, 1'b0) || q_mis[i] !== 1'b0) begin
        errors++; $display("FAIL fill_beat[%0d] got idx=%0d data=%h mis=%0d exp idx=%0d data=%h mis=0",
                           i, q_idx[i], q_data[i], q_mis[i], i, exp_val(i, 1'b0));
      end
    end
    checks++;
    if (q_data.size() != 32 || q_data[31] !== 32'h1F1F1F1F) begin
      errors++; $display("FAIL fill_idx31 got %h exp 1f1f1f1f", (q_data.size() == 32) ? q_data[31] : 32'hx);
    end
    checks++;
    if (scan_cycles != 130) begin
      errors++; $display("FAIL fill_latency got %0d exp 130", scan_cycles);
    end
    checks++;
    if (mismatch_count !== 6'd0 || done_cnt != 1) begin
      errors++; $display("FAIL fill_count got cnt=%0d done=%0d exp cnt=0 done=1", mismatch_count, done_cnt);
    end
  endtask

  task automatic test_invert;
    run_scan(1'b1, 1'b1, 100, 1'b0);
    checks++;
    if (q_idx.size() != 32) begin
      errors++; $display("FAIL inv_beats got %0d exp 32", q_idx.size());
    end else begin
      checks++;
      if (q_data[3] !== 32'hFCFCFCFC) begin
        errors++; $display("FAIL inv_idx3 got %h exp fcfcfcfc", q_data[3]);
      end
      checks++;
      if (q_data[0] !== 32'd0 || q_mis[0] !== 1'b0) begin
        errors++; $display("FAIL inv_idx0 got data=%h mis=%0d exp data=0 mis=0", q_data[0], q_mis[0]);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (q_idx[i] != i || q_data[i] !== exp_val(i, 1'b1)) begin
          errors++; $display("FAIL inv_beat[%0d] got idx=%0d data=%h exp data=%h", i, q_idx[i], q_data[i], exp_val(i, 1'b1));
        end
      end
    end
  endtask

  task automatic test_dump_only;
    run_scan(1'b0, 1'b0, 100, 1'b0);
    checks++;
    if (scan_cycles != 98 || q_idx.size() != 32) begin
      errors++; $display("FAIL dump_latency got %0d beats=%0d exp 98 beats=32", scan_cycles, q_idx.size());
    end
  endtask

  task automatic test_backpressure;
    run_scan(1'b0, 1'b0, 50, 1'b0);
    checks++;
    if (timed_out || q_idx.size() != 32) begin
      errors++; $display("FAIL bp_beats got %0d (timeout %0d) exp 32", q_idx.size(), timed_out);
    end
    for (int i = 0; i < q_idx.size() && i < 32; i++) begin
      checks++;
      if (q_idx[i] != i || q_data[i] !== exp_val(i, 1'b1)) begin
        errors++; $display("FAIL bp_beat[%0d] got idx=%0d data=%h exp idx=%0d data=%h", i, q_idx[i], q_data[i], i, exp_val(i, 1'b1));
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL bp_hold got %0d violations exp 0", stab_err);
    end
  endtask

  task automatic test_fault;
    fault_en = 1'b1;
    run_scan(1'b0, 1'b1, 100, 1'b0);
    fault_en = 1'b0;
    checks++;
    if (q_idx.size() != 32) begin
      errors++; $display("FAIL fault_beats got %0d exp 32", q_idx.size());
    end
    for (int i = 0; i < q_idx.size() && i < 32; i++) begin
      checks++;
      if (q_mis[i] !== ((i == 7) || (i == 20)) || q_data[i] !== exp_val(i, 1'b1)) begin
        errors++; $display("FAIL fault_beat[%0d] got mis=%0d data=%h exp mis=%0d data=%h",
                           i, q_mis[i], q_data[i], (i == 7) || (i == 20), exp_val(i, 1'b1));
      end
    end
    checks++;
    if (mismatch_count !== 6'd2) begin
      errors++; $display("FAIL fault_count got %0d exp 2", mismatch_count);
    end
  endtask

  task automatic test_reset_mid_fill;
    int wr = 0;
    int n = 0;
    @(posedge clock); #1;
    start = 1'b1; fill_en = 1'b1; pattern_invert = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    while (wr < 10 && n < 100) begin
      @(negedge clock);
      if (ctrl_writeEn === 1'b1) wr++;
      n++;
    end
    checks++;
    if (wr != 10) begin
      errors++; $display("FAIL rst_fill_reach got %0d writes exp 10", wr);
    end
    #1 ctrl_reset = 1'b0;
    #1;
    checks++;
    if (ctrl_writeEn !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async got we=%0d busy=%0d exp 0 0", ctrl_writeEn, busy);
    end
    checks++;
    if (mismatch_count !== 6'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got cnt=%0d valid=%0d exp 0 0", mismatch_count, out_valid);
    end
    @(posedge clock); #1 ctrl_reset = 1'b1;
    run_scan(1'b1, 1'b0, 100, 1'b0);
    checks++;
    if (q_idx.size() != 32 || scan_cycles != 130) begin
      errors++; $display("FAIL rst_rescan got beats=%0d cycles=%0d exp 32 130", q_idx.size(), scan_cycles);
    end
    for (int i = 0; i < q_idx.size() && i < 32; i++) begin
      checks++;
      if (q_data[i] !== exp_val(i, 1'b0)) begin
        errors++; $display("FAIL rst_beat[%0d] got %h exp %h", i, q_data[i], exp_val(i, 1'b0));
      end
    end
  endtask

  task automatic test_start_ignored;
    run_scan(1'b1, 1'b1, 100, 1'b1);
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_done got done=%0d busy=%0d exp 1 0", done_cnt, busy);
    end
    checks++;
    if (q_idx.size() != 32 || scan_cycles != 130) begin
      errors++; $display("FAIL ign_scan got beats=%0d cycles=%0d exp 32 130", q_idx.size(), scan_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_fill_dump();
    test_dump_only();
    test_invert();
    test_backpressure();
    test_fault();
    test_reset_mid_fill();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
